// File: rtl/instr_fetch_mem_pkg.sv
// Shared types and default geometry for the loadable instruction memory.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_mem_pkg;

  // Default geometry: 4-bit cells, 16-bit instructions, 64 cells.
  localparam int IMEM_CELL_W = 4;
  localparam int IMEM_WORD_W = 16;
  localparam int IMEM_DEPTH  = 64;
  localparam logic [IMEM_WORD_W-1:0] IMEM_NOP = 16'h0000;

  // LOAD blocks fetches until the loader signals completion.
  // RUN serves fetches and still accepts loader writes for patching.
  typedef enum logic [0:0] {
    IMEM_S_LOAD = 1'b0,
    IMEM_S_RUN  = 1'b1
  } imem_state_e;

endpackage

// File: rtl/instr_fetch_mem_cell_array.sv
// DEPTH x CELL_W cell storage: one write port, one CPW-cell combinational read.
// Latency: write lands at the clock edge; read is combinational (old data in write cycle).
// Backpressure: none, every enabled write is taken.
// Ports: clk; we_i/waddr_i/wdata_i write port; raddr_i base address; rd_dat_o CPW cells,
//   lowest address in the MSBs. No reset: contents survive a system reset.
module imem_cell_array #(
  parameter int    CELL_W    = 4,
  parameter int    DEPTH     = 64,
  parameter int    CPW       = 4,
  parameter string INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         we_i,
  input  logic [$clog2(DEPTH)-1:0]     waddr_i,
  input  logic [CELL_W-1:0]            wdata_i,
  input  logic [$clog2(DEPTH)-1:0]     raddr_i,
  output logic [CPW*CELL_W-1:0]        rd_dat_o
);

  localparam int AW = $clog2(DEPTH);

  logic [CELL_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Big-endian gather; the index wraps modulo DEPTH, which only matters for
  // out-of-range bases whose data the top level replaces with a NOP anyway.
  always_comb begin
    rd_dat_o = '0;
    for (int i = 0; i < CPW; i++) begin
      rd_dat_o[(CPW-1-i)*CELL_W +: CELL_W] = mem_q[raddr_i + AW'(i)];
    end
  end

endmodule

// File: rtl/instr_fetch_mem.sv
// Loadable instruction memory with a registered fetch port between the PC and IF/ID.
// Latency: one cycle from accepted fetch to if_valid_o/if_instr_o.
// Backpressure: if_ready_o low in LOAD or while stalled; loader writes always accepted.
// Ports: ld_* loader (cell writes, ld_done_i ends boot load); if_req_i/if_addr_i fetch
//   request; if_stall_i holds outputs; if_flush_i kills the in-flight fetch;
//   if_valid_o/if_instr_o/if_fault_o registered fetch result.
module instr_fetch_mem import instr_fetch_mem_pkg::*; #(
  parameter int                 CELL_W      = IMEM_CELL_W,
  parameter int                 WORD_W      = IMEM_WORD_W,
  parameter int                 DEPTH       = IMEM_DEPTH,
  parameter bit                 ALIGN_CHECK = 1'b1,
  parameter logic [WORD_W-1:0]  NOP_WORD    = '0,
  parameter bit                 BOOT_LOAD   = 1'b1,
  parameter string              INIT_FILE   = ""
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      ld_valid_i,
  input  logic [$clog2(DEPTH)-1:0]  ld_addr_i,
  input  logic [CELL_W-1:0]         ld_data_i,
  input  logic                      ld_done_i,
  output logic                      ld_ready_o,
  input  logic                      if_req_i,
  input  logic [WORD_W-1:0]         if_addr_i,
  input  logic                      if_stall_i,
  input  logic                      if_flush_i,
  output logic                      if_ready_o,
  output logic                      if_valid_o,
  output logic [WORD_W-1:0]         if_instr_o,
  output logic                      if_fault_o
);

  localparam int CPW = WORD_W / CELL_W;
  localparam int AW  = $clog2(DEPTH);
  // First base address whose last cell would fall past the end of the array.
  localparam logic [WORD_W-1:0] ADDR_LIMIT = WORD_W'(DEPTH - CPW + 1);

  imem_state_e       state_q, state_d;
  logic              vld_q, vld_d;
  logic [WORD_W-1:0] instr_q, instr_d;
  logic              fault_q, fault_d;

  logic              fetch_acc;
  logic              range_err;
  logic              align_err;
  logic              mem_we;
  logic [WORD_W-1:0] rd_dat;

  assign ld_ready_o = (state_q == IMEM_S_LOAD) || (state_q == IMEM_S_RUN);
  assign if_ready_o = (state_q == IMEM_S_RUN) && !if_stall_i;
  assign fetch_acc  = if_req_i && if_ready_o;

  // Full-width compare so upper PC bits cannot alias into the array.
  assign range_err = (if_addr_i >= ADDR_LIMIT);
  assign align_err = ALIGN_CHECK && ((if_addr_i % WORD_W'(CPW)) != '0);

  // Gating with rst_n drops a write that coincides with reset assertion.
  assign mem_we = ld_valid_i && ld_ready_o && rst_n;

  imem_cell_array #(
    .CELL_W    (CELL_W),
    .DEPTH     (DEPTH),
    .CPW       (CPW),
    .INIT_FILE (INIT_FILE)
  ) u_cells (
    .clk      (clk),
    .we_i     (mem_we),
    .waddr_i  (ld_addr_i),
    .wdata_i  (ld_data_i),
    .raddr_i  (if_addr_i[AW-1:0]),
    .rd_dat_o (rd_dat)
  );

  always_comb begin
    state_d = state_q;
    if (state_q == IMEM_S_LOAD && ld_done_i) begin
      state_d = IMEM_S_RUN;
    end
  end

  // Flush beats stall; stall beats a new fetch (none is accepted anyway).
  always_comb begin
    vld_d   = vld_q;
    instr_d = instr_q;
    fault_d = fault_q;
    if (if_flush_i) begin
      vld_d   = 1'b0;
      fault_d = 1'b0;
    end else if (if_stall_i) begin
      vld_d   = vld_q;
    end else if (fetch_acc) begin
      vld_d   = 1'b1;
      fault_d = range_err || align_err;
      instr_d = (range_err || align_err) ? NOP_WORD : rd_dat;
    end else begin
      vld_d   = 1'b0;
      fault_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= BOOT_LOAD ? IMEM_S_LOAD : IMEM_S_RUN;
      vld_q   <= 1'b0;
      instr_q <= NOP_WORD;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

  assign if_valid_o = vld_q;
  assign if_instr_o = instr_q;
  assign if_fault_o = fault_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Directed bench for instr_fetch_mem: boot gating, load/fetch, faults, read-during-write,
// stall/flush, idle, reset retention and same-cycle write+done.
// Latency: n/a. Backpressure: n/a.
module tb_instr_fetch_mem;

  logic        clk;
  logic        rst_n;
  logic        ld_valid;
  logic [5:0]  ld_addr;
  logic [3:0]  ld_data;
  logic        ld_done;
  logic        ld_ready;
  logic        if_req;
  logic [15:0] if_addr;
  logic        if_stall;
  logic        if_flush;
  logic        if_ready;
  logic        if_valid;
  logic [15:0] if_instr;
  logic        if_fault;

  int n_chk = 0;
  int n_bad = 0;

  instr_fetch_mem #(
    .CELL_W      (4),
    .WORD_W      (16),
    .DEPTH       (64),
    .ALIGN_CHECK (1'b1),
    .NOP_WORD    (16'h0000),
    .BOOT_LOAD   (1'b1),
    .INIT_FILE   ("")
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ld_valid_i (ld_valid),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data),
    .ld_done_i  (ld_done),
    .ld_ready_o (ld_ready),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_stall_i (if_stall),
    .if_flush_i (if_flush),
    .if_ready_o (if_ready),
    .if_valid_o (if_valid),
    .if_instr_o (if_instr),
    .if_fault_o (if_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge and settle, so checks sample away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_cell(input logic [5:0] a, input logic [3:0] d);
    ld_valid = 1'b1;
    ld_addr  = a;
    ld_data  = d;
    step();
    ld_valid = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] a);
    if_req  = 1'b1;
    if_addr = a;
    step();
    if_req  = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic        fault;
    logic [15:0] instr;
  } fvec_t;

  initial begin
    fvec_t vecs[4];
    vecs[0] = '{16'h003E, 1'b1, 16'h0000}; // out of range
    vecs[1] = '{16'h0009, 1'b1, 16'h0000}; // misaligned
    vecs[2] = '{16'h0108, 1'b1, 16'h0000}; // upper bits set
    vecs[3] = '{16'h0008, 1'b0, 16'h370E}; // back to a good word

    rst_n = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; ld_done = 1'b0;
    if_req = 1'b0; if_addr = '0; if_stall = 1'b0; if_flush = 1'b0;
    #3;
    check_eq("rst_valid", 32'(if_valid), 32'd0);
    check_eq("rst_instr", 32'(if_instr), 32'h0);
    check_eq("rst_fault", 32'(if_fault), 32'd0);
    check_eq("rst_if_ready", 32'(if_ready), 32'd0);
    check_eq("rst_ld_ready", 32'(ld_ready), 32'd1);
    step();
    rst_n = 1'b1;

    // Boot gating: fetch requests are refused until ld_done.
    if_req = 1'b1; if_addr = 16'h0008;
    #1;
    check_eq("boot_if_ready", 32'(if_ready), 32'd0);
    step();
    check_eq("boot_valid", 32'(if_valid), 32'd0);
    if_req = 1'b0;
    ld_done = 1'b1;
    step();
    ld_done = 1'b0;
    check_eq("run_if_ready", 32'(if_ready), 32'd1);

    // Load in RUN (patch path) and fetch.
    write_cell(6'd8,  4'h3);
    write_cell(6'd9,  4'h7);
    write_cell(6'd10, 4'h0);
    write_cell(6'd11, 4'hE);
    fetch(16'h0008);
    check_eq("fetch8_valid", 32'(if_valid), 32'd1);
    check_eq("fetch8_instr", 32'(if_instr), 32'h370E);
    check_eq("fetch8_fault", 32'(if_fault), 32'd0);

    // Fault table.
    foreach (vecs[i]) begin
      fetch(vecs[i].addr);
      check_eq($sformatf("fv%0d_valid", i), 32'(if_valid), 32'd1);
      check_eq($sformatf("fv%0d_fault", i), 32'(if_fault), 32'(vecs[i].fault));
      check_eq($sformatf("fv%0d_instr", i), 32'(if_instr), 32'(vecs[i].instr));
    end
    // Highest legal base: in range and aligned.
    fetch(16'h003C);
    check_eq("edge60_fault", 32'(if_fault), 32'd0);
    // First illegal aligned base.
    fetch(16'h0040);
    check_eq("edge64_fault", 32'(if_fault), 32'd1);

    // Stall: outputs hold and no new fetch is taken.
    fetch(16'h0008);
    if_stall = 1'b1; if_req = 1'b1; if_addr = 16'h003E;
    #1;
    check_eq("stall_if_ready", 32'(if_ready), 32'd0);
    for (int k = 0; k < 3; k++) begin
      step();
      check_eq($sformatf("stall%0d_valid", k), 32'(if_valid), 32'd1);
      check_eq($sformatf("stall%0d_instr", k), 32'(if_instr), 32'h370E);
      check_eq($sformatf("stall%0d_fault", k), 32'(if_fault), 32'd0);
    end
    if_req = 1'b0;
    if_flush = 1'b1;
    step();
    check_eq("flush_stall_valid", 32'(if_valid), 32'd0);
    if_stall = 1'b0;

    // Flush discards a fetch accepted in the same cycle.
    fetch(16'h0008);
    check_eq("flush_fetch_valid", 32'(if_valid), 32'd0);
    if_flush = 1'b0;

    // Idle drops valid.
    fetch(16'h0008);
    check_eq("pre_idle_valid", 32'(if_valid), 32'd1);
    step();
    check_eq("idle_valid", 32'(if_valid), 32'd0);

    // Read-during-write returns old data, new data on the next fetch.
    ld_valid = 1'b1; ld_addr = 6'd9; ld_data = 4'hF;
    fetch(16'h0008);
    ld_valid = 1'b0;
    check_eq("rdw_old", 32'(if_instr), 32'h370E);
    fetch(16'h0008);
    check_eq("rdw_new", 32'(if_instr), 32'h3F0E);

    // Asynchronous reset mid-run.
    check_eq("pre_rst_valid", 32'(if_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check_eq("arst_valid", 32'(if_valid), 32'd0);
    check_eq("arst_instr", 32'(if_instr), 32'h0);
    check_eq("arst_load_state", 32'(if_ready), 32'd0);
    step();
    rst_n = 1'b1;

    // Back in LOAD: write 12..14, last write together with ld_done.
    write_cell(6'd12, 4'h1);
    write_cell(6'd13, 4'h2);
    write_cell(6'd14, 4'h4);
    ld_done = 1'b1;
    write_cell(6'd15, 4'h5);
    ld_done = 1'b0;
    fetch(16'h000C);
    check_eq("done_wr_instr", 32'(if_instr), 32'h1245);
    check_eq("done_wr_valid", 32'(if_valid), 32'd1);
    fetch(16'h0008);
    check_eq("retained_instr", 32'(if_instr), 32'h3F0E);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
